// File: rtl/bitonic_pkg.sv
// Shared types and constants for the sequential 8-element bitonic sorter:
// FSM states, batch size, compare count and the fixed compare-swap schedule.
package bitonic_pkg;

   localparam int NUM_ELEM = 8;
   localparam int NUM_CMP  = 24;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SORT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // dir = 1: slot i takes the max, slot l the min
   typedef struct packed {
      logic [2:0] i;
      logic [2:0] l;
      logic       dir;
   } cas_op_t;

   localparam cas_op_t SCHED [NUM_CMP] = '{
      {3'd0, 3'd1, 1'b1}, {3'd2, 3'd3, 1'b0}, {3'd4, 3'd5, 1'b1}, {3'd6, 3'd7, 1'b0},
      {3'd0, 3'd2, 1'b1}, {3'd1, 3'd3, 1'b1}, {3'd4, 3'd6, 1'b0}, {3'd5, 3'd7, 1'b0},
      {3'd0, 3'd1, 1'b1}, {3'd2, 3'd3, 1'b1}, {3'd4, 3'd5, 1'b0}, {3'd6, 3'd7, 1'b0},
      {3'd0, 3'd4, 1'b1}, {3'd1, 3'd5, 1'b1}, {3'd2, 3'd6, 1'b1}, {3'd3, 3'd7, 1'b1},
      {3'd0, 3'd2, 1'b1}, {3'd1, 3'd3, 1'b1}, {3'd4, 3'd6, 1'b1}, {3'd5, 3'd7, 1'b1},
      {3'd0, 3'd1, 1'b1}, {3'd2, 3'd3, 1'b1}, {3'd4, 3'd5, 1'b1}, {3'd6, 3'd7, 1'b1}
   };

endpackage

// File: rtl/bitonic_seq_sorter_if.sv
// Load/drain handshake bundle of the bitonic sorter; the sorter is the slave,
// the producer/consumer side is the master.
interface bitonic_seq_sorter_if #(
   parameter int DW = 8
);
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/bitonic_cas.sv
// Single combinational compare-swap; hi_slot is written back to the lower
// slot index i, lo_slot to the higher index l. Equal values never swap.
module bitonic_cas #(
   parameter int DW = 8
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic          dir,
   output logic [DW-1:0] hi_slot,
   output logic [DW-1:0] lo_slot
);
   logic swap_s;

   assign swap_s  = dir ? (b > a) : (a > b);
   assign hi_slot = swap_s ? b : a;
   assign lo_slot = swap_s ? a : b;
endmodule

// File: rtl/bitonic_seq_sorter.sv
// Sequential 8-element bitonic sorter: loads a batch, runs 24 single
// compare-swap cycles through one shared bitonic_cas, then drains largest first.
module bitonic_seq_sorter
   import bitonic_pkg::*;
#(
   parameter int DW = 8,
   parameter int N  = NUM_ELEM
) (
   input  logic                 clk,
   input  logic                 reset,
   bitonic_seq_sorter_if.slave  bus,
   output logic                 busy
);
   state_t        state_r;
   logic [2:0]    load_cnt_r;
   logic [4:0]    pair_cnt_r;
   logic [2:0]    drain_idx_r;
   logic [DW-1:0] slot_r [N];
   logic          in_ready_r;
   logic          out_valid_r;
   logic          busy_r;
   logic [DW-1:0] out_data_r;

   cas_op_t       op_s;
   logic [DW-1:0] cas_a_s;
   logic [DW-1:0] cas_b_s;
   logic [DW-1:0] cas_hi_s;
   logic [DW-1:0] cas_lo_s;

   assign op_s    = SCHED[pair_cnt_r];
   assign cas_a_s = slot_r[op_s.i];
   assign cas_b_s = slot_r[op_s.l];

   bitonic_cas #(.DW(DW)) u_cas (
      .a       (cas_a_s),
      .b       (cas_b_s),
      .dir     (op_s.dir),
      .hi_slot (cas_hi_s),
      .lo_slot (cas_lo_s)
   );

   // FSM, element slots, counters and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= LOAD;
         load_cnt_r  <= 3'd0;
         pair_cnt_r  <= 5'd0;
         drain_idx_r <= 3'd0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         out_data_r  <= '0;
         for (int s = 0; s < N; s++) begin
            slot_r[s] <= '0;
         end
      end else begin
         case (state_r)
            LOAD: begin
               if (bus.in_valid) begin
                  slot_r[load_cnt_r] <= bus.in_data;
                  if (load_cnt_r == 3'(N - 1)) begin
                     state_r    <= SORT;
                     load_cnt_r <= 3'd0;
                     pair_cnt_r <= 5'd0;
                     in_ready_r <= 1'b0;
                     busy_r     <= 1'b1;
                  end else begin
                     load_cnt_r <= load_cnt_r + 3'd1;
                  end
               end
            end
            SORT: begin
               slot_r[op_s.i] <= cas_hi_s;
               slot_r[op_s.l] <= cas_lo_s;
               if (pair_cnt_r == 5'(NUM_CMP - 1)) begin
                  state_r     <= DRAIN;
                  pair_cnt_r  <= 5'd0;
                  drain_idx_r <= 3'd0;
                  busy_r      <= 1'b0;
                  out_valid_r <= 1'b1;
                  // slot 0 may be written by this very compare
                  out_data_r  <= (op_s.i == 3'd0) ? cas_hi_s : slot_r[0];
               end else begin
                  pair_cnt_r <= pair_cnt_r + 5'd1;
               end
            end
            DRAIN: begin
               if (bus.out_ready) begin
                  if (drain_idx_r == 3'(N - 1)) begin
                     state_r     <= LOAD;
                     drain_idx_r <= 3'd0;
                     load_cnt_r  <= 3'd0;
                     out_valid_r <= 1'b0;
                     out_data_r  <= '0;
                     in_ready_r  <= 1'b1;
                  end else begin
                     drain_idx_r <= drain_idx_r + 3'd1;
                     out_data_r  <= slot_r[drain_idx_r + 3'd1];
                  end
               end
            end
            default: begin
               state_r     <= LOAD;
               load_cnt_r  <= 3'd0;
               pair_cnt_r  <= 5'd0;
               drain_idx_r <= 3'd0;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               out_data_r  <= '0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign busy          = busy_r;
endmodule

// File: tb/tb_bitonic_seq_sorter.sv
// Scoreboard bench for bitonic_seq_sorter: directed batches push hand-sorted
// expectations; a negedge monitor pops and checks every drained element.
module tb_bitonic_seq_sorter;
   logic clk = 1'b0;
   logic reset;
   logic busy;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic [7:0] exp_q [$];

   int   in_cnt = 0;
   int   pop_cnt = 0;
   int   busy_cnt = 0;
   int   hs8_cyc = 0;
   bit   armed = 1'b0;
   bit   expect_load = 1'b0;
   bit   prev_ov = 1'b0;

   bitonic_seq_sorter_if #(.DW(8)) bus ();

   bitonic_seq_sorter #(.DW(8), .N(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] need);
      checks++;
      if (got !== need) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, need, cyc);
      end
   endtask

   task automatic push_exp(input logic [63:0] e);
      for (int k = 0; k < 8; k++) exp_q.push_back(e[63 - 8*k -: 8]);
   endtask

   task automatic send_elem(input logic [7:0] v);
      int   t;
      logic hs;
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      t = 0;
      do begin
         @(negedge clk);
         hs = bus.in_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!hs && t < 200);
      if (!hs) chk("in_handshake_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_batch(input logic [63:0] s, input bit keep_valid);
      for (int k = 0; k < 8; k++) send_elem(s[63 - 8*k -: 8]);
      if (!keep_valid) bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid();
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!bus.out_valid && t < 100);
      if (!bus.out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
   endtask

   // monitor: scoreboard pops, latency, busy length and idle-output rules
   always @(negedge clk) begin
      logic [7:0] e;
      if (reset) begin
         in_cnt = 0; pop_cnt = 0; busy_cnt = 0;
         armed = 1'b0; expect_load = 1'b0; prev_ov = 1'b0;
      end else begin
         if (expect_load) begin
            chk("load_reopen_in_ready", 32'(bus.in_ready), 32'd1);
            expect_load = 1'b0;
         end
         if (busy) busy_cnt++;
         if (busy || bus.out_valid) chk("in_ready_blocked", 32'(bus.in_ready), 32'd0);
         if (!bus.out_valid) chk("out_data_idle_zero", 32'(bus.out_data), 32'd0);
         if (bus.out_valid && !prev_ov && armed) begin
            chk("first_out_latency", 32'(cyc - hs8_cyc), 32'd25);
            chk("busy_cycles", 32'(busy_cnt), 32'd24);
            armed = 1'b0;
            busy_cnt = 0;
         end
         if (bus.in_valid && bus.in_ready) begin
            in_cnt++;
            if (in_cnt == 8) begin
               in_cnt = 0; hs8_cyc = cyc; armed = 1'b1; busy_cnt = 0;
            end
         end
         if (bus.out_valid && !bus.out_ready && exp_q.size() > 0)
            chk("stall_hold_data", 32'(bus.out_data), 32'(exp_q[0]));
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 32'(bus.out_data), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", 32'(bus.out_data), 32'(e));
               pop_cnt++;
               if (pop_cnt == 8) begin
                  pop_cnt = 0;
                  expect_load = 1'b1;
               end
            end
         end
         prev_ov = bus.out_valid;
      end
   end

   initial begin
      reset = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = 8'h00;
      bus.out_ready = 1'b1;
      #2 reset = 1'b1;
      #1;
      chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_out_data", 32'(bus.out_data), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;

      // ascending input
      push_exp(64'h08_07_06_05_04_03_02_01);
      send_batch(64'h01_02_03_04_05_06_07_08, 1'b0);
      wait_drain();

      // unsigned extremes with duplicates
      push_exp(64'hFF_FE_80_80_7F_01_00_00);
      send_batch(64'hFF_00_7F_80_01_FE_80_00, 1'b0);
      wait_drain();

      // all equal
      push_exp(64'h55_55_55_55_55_55_55_55);
      send_batch(64'h55_55_55_55_55_55_55_55, 1'b0);
      wait_drain();

      // stall at drain index 3 with stray in_valid during SORT/DRAIN
      push_exp(64'hF2_90_66_5E_4B_3A_1C_07);
      send_batch(64'h3A_1C_5E_07_F2_90_4B_66, 1'b1);
      bus.in_data = 8'hAA;
      wait_valid();
      repeat (3) @(posedge clk);
      #1 bus.out_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b0;
      wait_drain();

      // reset in SORT cycle 10 discards the batch
      send_batch(64'hE0_E1_E2_E3_E4_E5_E6_E7, 1'b0);
      repeat (9) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("midsort_reset_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midsort_reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midsort_reset_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #2 reset = 1'b0;
      @(posedge clk);
      #1;
      push_exp(64'h17_16_15_14_13_12_11_10);
      send_batch(64'h10_11_12_13_14_15_16_17, 1'b0);
      wait_drain();

      // back-to-back batches with in_valid held high
      push_exp(64'hE5_A1_99_77_42_12_0C_03);
      push_exp(64'hC0_80_80_7F_40_3F_01_00);
      send_batch(64'h42_03_A1_77_0C_99_E5_12, 1'b1);
      send_batch(64'h80_80_01_7F_C0_00_3F_40, 1'b0);
      wait_drain();

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bitonic_seq_sorter.md
BITONIC_SEQ_SORTER -- requirements
Module: bitonic_seq_sorter

Interface
REQ-001 Parameter: DW, default 8, data word width in bits.
REQ-002 Parameter: N, default 8, number of elements per sort batch; only the value 8 is supported.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_data  input  DW  unsigned element to load.
REQ-007 in_ready  output  1  block accepts an element this cycle.
REQ-008 out_valid  output  1  out_data holds a sorted element.
REQ-009 out_data  output  DW  sorted element, largest first.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 busy  output  1  high while in state SORT.

Function
REQ-012 The block SHALL implement a three-state FSM: LOAD, SORT and DRAIN.
REQ-013 In LOAD, in_ready SHALL be 1, and each cycle with in_valid=1 SHALL write in_data to element slot load_cnt, where load_cnt runs 0..7.
REQ-014 The edge that accepts the 8th element SHALL move the FSM to SORT and clear the pair counter.
REQ-015 In SORT, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-016 In SORT, each cycle SHALL perform exactly one compare-swap on slots (i, l) and write both results back at the clock edge.
- l = i XOR j, with i < l.
- The pair order is the standard bitonic order for 8 elements: k = 2, 4, 8; for each k, j = k/2 down to 1; then i ascending, taking only values with (i AND j) = 0.
- This gives 6 stages of 4 pairs, 24 cycles in total.
REQ-017 The swap direction for each pair SHALL be as follows:
- If (i AND k) = 0, slot i receives max and slot l receives min.
- Otherwise, slot i receives min and slot l receives max.
- The final result is in descending order, with slot 0 holding the largest element.
REQ-018 Comparison SHALL be unsigned over the full DW bits; equal values SHALL leave both slots unchanged.
REQ-019 The edge performing the 24th compare SHALL move the FSM to DRAIN with the drain index at 0.
REQ-020 out_valid SHALL rise in the cycle following that edge, so the first out_valid occurs 25 cycles after the 8th input handshake edge.
REQ-021 In DRAIN, out_valid SHALL be 1 and out_data SHALL equal slot[drain index].
REQ-022 A DRAIN cycle with out_ready=1 SHALL advance the drain index.
- While out_ready=0, out_data and out_valid SHALL hold.
REQ-023 The handshake on drain index 7 SHALL return the FSM to LOAD, with load_cnt at 0 and out_valid low in the next cycle.
REQ-024 Outside DRAIN, out_valid SHALL be 0 and out_data SHALL be 0.
REQ-025 busy SHALL be 1 exactly during the 24 SORT cycles.
REQ-026 No element SHALL be accepted outside LOAD, and no element SHALL be lost or duplicated across back-to-back batches.

Reset
REQ-027 Asserting reset at any time, including mid-LOAD, mid-SORT or mid-DRAIN, SHALL immediately force the following, without waiting for a clock edge:
- FSM to LOAD.
- load_cnt, pair counter and drain index to 0.
- in_ready to 1.
- out_valid, busy and out_data to 0.
REQ-028 Reset SHALL clear all element slots to 0, and any partial batch SHALL be discarded.

Structure
REQ-029 A shared package bitonic_pkg SHALL hold:
- the FSM state enumeration;
- the constant N = 8;
- the constant number of compare cycles, 24;
- the 24-entry schedule table of (i, l, direction) constants.
REQ-030 A combinational sub-module bitonic_cas SHALL perform the single shared compare-swap.
- Inputs: a, b, dir.
- Outputs: hi_slot, lo_slot.
- It SHALL have no state, and exactly one instance SHALL exist.
REQ-031 The element slots, counters and FSM SHALL reside in bitonic_seq_sorter.

Verification
REQ-032 The bench SHALL load 0x01..0x08 in ascending order with out_ready=1 -> out_data 0x08,0x07,...,0x01, and the first out_valid 25 cycles after the 8th handshake.
REQ-033 The bench SHALL load 0xFF,0x00,0x7F,0x80,0x01,0xFE,0x80,0x00 -> out_data 0xFF,0xFE,0x80,0x80,0x7F,0x01,0x00,0x00 (unsigned order, duplicates kept).
REQ-034 The bench SHALL load eight copies of 0x55 -> eight outputs of 0x55, with busy high for exactly 24 cycles.
REQ-035 The bench SHALL hold out_ready=0 for 5 cycles at drain index 3 -> out_data is stable at the 4th-largest value and the drain index does not advance.
- The same test SHALL present in_valid=1 during SORT/DRAIN -> it is ignored.
REQ-036 The bench SHALL assert reset at SORT cycle 10 -> in_ready=1 and out_valid=0 immediately.
- A fresh batch 0x10..0x17 then SHALL sort to 0x17..0x10 with no residue from the aborted batch.
REQ-037 The bench SHALL run two back-to-back batches, with in_valid asserted continuously after the drain -> both batches are sorted correctly and the second LOAD begins the cycle after the 8th drain handshake.
